// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the RISC-V multi-cycle controller: state enum,
// opcodes, datapath mux/ALU encodings and the per-state control word.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR_CALC,
        S_JALR_JUMP,
        S_LUI,
        S_HALT
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_U    = 7'b0110111;
    localparam logic [6:0] OP_J    = 7'b1101111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_t;

    function automatic logic is_known_op(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_S, OP_B, OP_U, OP_J, OP_LW, OP_JALR};
    endfunction

endpackage

// File: rtl/riscv_imm_src_decode.sv
// Combinational opcode -> immediate-format select; anything without an S/B/J/U
// immediate (including unknown opcodes) maps to the I format.
module riscv_imm_src_decode
    import riscv_mc_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] immSrc
);

    always_comb begin
        case (op)
            OP_S:    immSrc = IMM_S;
            OP_B:    immSrc = IMM_B;
            OP_J:    immSrc = IMM_J;
            OP_U:    immSrc = IMM_U;
            default: immSrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_controller.sv
// Main FSM of the multi-cycle RISC-V datapath with memory-ready stalls and a
// wait timeout. Define ILLEGAL_OP_TRAP_EN to halt on unknown opcodes.
module riscv_multicycle_controller
    import riscv_mc_pkg::*;
#(
    parameter int MAX_WAIT = 15
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       brCond,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] immSrc,
    output logic       memErr,
    output logic       instrDone
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic       illegalOp
`endif
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          mem_err_q;
    logic          mem_state;
    logic          timeout;
    ctrl_t         ctrl;
    logic [2:0]    imm_src_dec;
`ifdef ILLEGAL_OP_TRAP_EN
    logic          illegal_q;
`endif

    // The timeout cycle is the one that starts with MAX_WAIT stalls already counted.
    assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timeout   = mem_state && !memReady && (wait_cnt == CW'(MAX_WAIT));

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else if (timeout) begin
            state     <= S_HALT;
            wait_cnt  <= '0;
            mem_err_q <= 1'b1;
        end else begin
            wait_cnt <= (mem_state && !memReady) ? wait_cnt + 1'b1 : '0;
            case (state)
                S_FETCH:     if (memReady) state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_S: state <= S_MEMADR;
                        OP_R:        state <= S_EXEC_R;
                        OP_I:        state <= S_EXEC_I;
                        OP_B:        state <= S_BRANCH;
                        OP_J:        state <= S_JAL;
                        OP_JALR:     state <= S_JALR_CALC;
                        OP_U:        state <= S_LUI;
                        default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                            state     <= S_HALT;
                            illegal_q <= 1'b1;
`else
                            state     <= S_FETCH;
`endif
                        end
                    endcase
                end
                S_MEMADR:    state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:   if (memReady) state <= S_MEMWB;
                S_MEMWRITE:  if (memReady) state <= S_FETCH;
                S_EXEC_R,
                S_EXEC_I,
                S_JAL,
                S_JALR_JUMP: state <= S_ALUWB;
                S_JALR_CALC: state <= S_JALR_JUMP;
                S_MEMWB,
                S_ALUWB,
                S_BRANCH,
                S_LUI:       state <= S_FETCH;
                default:     state <= S_HALT;
            endcase
        end
    end

    // NOTE: the control word gets a full default first so no output can infer a latch.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
                ctrl.ir_write   = memReady;
                ctrl.pc_update  = memReady;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
`ifndef ILLEGAL_OP_TRAP_EN
                ctrl.instr_done = !is_known_op(op);
`endif
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:   ctrl.adr_src = 1'b1;
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src    = 1'b1;
                ctrl.mem_write  = !timeout;
                ctrl.instr_done = memReady;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ITYPE;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_BRANCH;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JAL, S_JALR_JUMP: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
            end
            S_JALR_CALC: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_LUI: begin
                ctrl.result_src = RES_IMM;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
        if (rst) ctrl = '0;
    end

    riscv_imm_src_decode u_imm_src_decode (
        .op     (op),
        .immSrc (imm_src_dec)
    );

    assign pcWrite   = ctrl.pc_update | (ctrl.branch & brCond);
    assign adrSrc    = ctrl.adr_src;
    assign memWrite  = ctrl.mem_write;
    assign irWrite   = ctrl.ir_write;
    assign regWrite  = ctrl.reg_write;
    assign resultSrc = ctrl.result_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ALUOp     = ctrl.alu_op;
    assign instrDone = ctrl.instr_done;
    assign immSrc    = rst ? 3'b000 : imm_src_dec;
    assign memErr    = mem_err_q & ~rst;
`ifdef ILLEGAL_OP_TRAP_EN
    assign illegalOp = illegal_q & ~rst;
`endif

endmodule

// File: doc/riscv_multicycle_controller.md
Name: riscv_multicycle_controller

Overview:
- Moore-style main FSM that sequences the team's RISC-V multi-cycle datapath: one shared memory, one ALU, and IR/oldPC/ALUOut/Data registers.
- Each instruction is split into FETCH, DECODE, EXECUTE, MEM and WB steps.
- It stalls on a memory-ready handshake and flags stuck memory with a wait-timeout counter.
- It sits beside the ALU decoder, which turns ALUOp plus funct3/funct7 into the ALU control.

Parameters:
- MAX_WAIT, 15: consecutive cycles a memory state may wait for memReady before timeout. Must be ≥1; the counter is 4 bits wide for the default.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- op  in  7  IR[6:0], valid from DECODE onward
- brCond  in  1  branch condition from the datapath comparator (funct3 applied there)
- memReady  in  1  memory done this cycle (read data valid / write accepted)
- pcWrite  out  1  = pcUpdate | (branch & brCond)
- adrSrc  out  1  memory address: 0 PC, 1 ALUOut
- memWrite  out  1  memory write strobe
- irWrite  out  1  load IR and oldPC
- regWrite  out  1  register-file write
- resultSrc  out  2  result: 00 ALUOut, 01 Data reg, 10 ALU result, 11 imm
- ALUSrcA  out  2  ALU A: 00 PC, 01 oldPC, 10 rs1
- ALUSrcB  out  2  ALU B: 00 rs2, 01 imm, 10 constant 4
- ALUOp  out  2  00 add, 01 branch, 10 R-type, 11 I-type
- immSrc  out  3  I 000, S 001, B 010, J 011, U 100; combinational from op in every state; 000 for unknown op
- memErr  out  1  sticky memory timeout
- instrDone  out  1  one-cycle pulse on the last state of each instruction

Behaviour:
Reset and idle defaults:
- A cycle with rst=1 forces state FETCH, clears the wait counter and memErr, and forces all outputs to 0 that cycle.
- rst mid-instruction aborts it with no write issued.
- Outputs not listed for a state are 0.

States and transitions:
- FETCH: adrSrc=0; ALUSrcA=00, ALUSrcB=10, ALUOp=00, resultSrc=10.
  - irWrite and pcUpdate are asserted only when memReady=1.
  - memReady=1 → DECODE; otherwise stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (ALUOut = branch/JAL target).
  - Branch on op: LW/SW → MEMADR; R → EXEC_R; I → EXEC_I; B → BRANCH; JAL → JAL; JALR → JALR_CALC; LUI → LUI; other → FETCH with instrDone=1.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next is MEMREAD for LW, MEMWRITE for SW.
- MEMREAD: adrSrc=1; wait for memReady, then → MEMWB.
- MEMWB: resultSrc=01, regWrite=1, instrDone=1 → FETCH.
- MEMWRITE: adrSrc=1, memWrite=1, held until memReady; then instrDone=1 → FETCH.
- EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXEC_I: ALUSrcA=10, ALUSrcB=01, ALUOp=11 → ALUWB.
- ALUWB: resultSrc=00, regWrite=1, instrDone=1 → FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, resultSrc=00, branch=1; instrDone=1 → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, resultSrc=00, pcUpdate=1 → ALUWB.
- JALR_CALC: ALUSrcA=10, ALUSrcB=01, ALUOp=00 → JALR_JUMP.
- JALR_JUMP: ALUSrcA=01, ALUSrcB=10, resultSrc=00, pcUpdate=1 → ALUWB.
- LUI: resultSrc=11, regWrite=1, instrDone=1 → FETCH.
- HALT: all outputs 0; leave only on rst.

Memory wait timeout:
- The wait counter increments in FETCH/MEMREAD/MEMWRITE each cycle memReady=0.
- It clears on memReady=1 and on every state change.
- Reaching MAX_WAIT sets memErr=1 (sticky) and goes to HALT next cycle, with no strobe issued in the timeout cycle.
- memReady=1 in the same cycle the count reaches MAX_WAIT: ready wins, no error.

Optional Feature:
ILLEGAL_OP_TRAP_EN:
- Defined: an unknown op in DECODE → HALT, and output illegalOp (1 bit, sticky until rst) = 1.
- Undefined: the port is absent and an unknown op retires as a NOP (→ FETCH, instrDone=1).

Decomposition:
- Package riscv_mc_pkg holds:
  - the state enum, 4 bits;
  - opcode constants R/I/S/B/U/J/LW/JALR;
  - resultSrc/ALUSrc/ALUOp/immSrc encodings.
- One natural sub-module, riscv_imm_src_decode: the combinational op→immSrc map.

Test Plan:
- R-type add, memReady tied 1: FETCH, DECODE, EXEC_R, ALUWB = 4 cycles; regWrite=1 and instrDone=1 only in cycle 4; pcWrite=1 only in cycle 1.
- LW with memReady low for 3 cycles in MEMREAD: MEMREAD holds 4 cycles with adrSrc=1; memWrite stays 0; MEMWB then asserts resultSrc=01, regWrite=1.
- BEQ with brCond=1 then brCond=0: pcWrite=1 in BRANCH only when taken; ALUOp=01; no regWrite.
- JALR (op 1100111): states JALR_CALC, JALR_JUMP, ALUWB; pcWrite=1 in JALR_JUMP; immSrc=000 throughout.
- memReady held 0 in FETCH with MAX_WAIT=15: memErr rises after 15 stall cycles, FSM sits in HALT with all strobes 0, and rst=1 returns it to FETCH with memErr=0.
- Illegal op 7'b1111111, both macro settings: with the macro, HALT and illegalOp=1; without it, back to FETCH after DECODE with instrDone=1 and no writes.
